io_reg_arbiter: RTL and testbench
=================================

Name: io_reg_arbiter

Overview:
- Shares the single GPU I/O-register BRAM port between two requesters: requester 0 (host side, fed from the AXI-to-BRAM bridge path) and requester 1 (GPU command processor).
- Issues at most one access per cycle, with round-robin arbitration and optional short locked bursts.
- Returns read data to the requester that issued the read.
- Sits inside the GPU in front of the I/O-register memory; runs entirely in the gpu_clk domain.

Parameters:
- ADDR_W, 12, word address width of the register memory
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_BURST, 4, maximum consecutive grants to one requester while it holds lock (minimum 1)

Ports:
- gpu_clk  in  1  the block's single clock
- reset  in  1  synchronous, active-high reset
- mX_valid  in  1  requester X (X=0,1) has an access pending
- mX_ready  out  1  access accepted (issued to memory) this cycle
- mX_addr  in  ADDR_W  access address
- mX_we  in  DATA_W/8  byte write enables; all-zero means read
- mX_wdata  in  DATA_W  write data
- mX_lock  in  1  request to keep the grant on the next cycle
- mX_rvalid  out  1  read data valid for requester X
- mX_rdata  out  DATA_W  read data
- mem_en  out  1  memory enable
- mem_we  out  DATA_W/8  memory byte write enables
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data; valid 1 cycle after mem_en with mem_we==0

Behaviour:
- Interface: one clock, gpu_clk; reset is synchronous and active-high.
- Registered state:
  - last_gnt (1b): the requester served most recently.
  - burst_cnt (clog2(MAX_BURST) bits).
  - rd_pend (1b) and rd_owner (1b): read-return pipeline.
- Reset values: last_gnt=1 (so m0 wins the first contention), burst_cnt=0, rd_pend=0, rd_owner=0, m0_rvalid=m1_rvalid=0, rdata=0.
- Since valid=0 during reset, mem_en=0 and both ready=0.
- Grant selection is combinational each cycle:
  - Neither valid: no grant, mem_en=0, burst_cnt:=0.
  - One valid: grant it.
  - Both valid: grant the locked owner if last_gnt's lock was asserted on its previous granted access and burst_cnt<MAX_BURST-1; otherwise grant !last_gnt (round-robin).
- Issue:
  - mX_ready=1 only for the granted requester, in the same cycle as mem_en=1.
  - mem_we/mem_addr/mem_din are muxed from the granted requester.
  - When idle, mem_* outputs are 0.
- Handshake:
  - The requester holds valid/addr/we/wdata stable until ready.
  - Acceptance happens on the valid&ready clock edge.
- Burst counter on grant:
  - Grant to the same requester as last_gnt: burst_cnt := burst_cnt+1, saturating at MAX_BURST-1.
  - Grant to a different requester: burst_cnt := 0, last_gnt := granted.
- Lock limits:
  - Lock is honoured only under contention.
  - After MAX_BURST consecutive grants the other requester must win the next contended cycle, regardless of lock.
- Read return (latency 2 cycles from valid&ready edge to rvalid):
  - A read issue sets rd_pend=1 and rd_owner=granted.
  - On the following edge, m[rd_owner]_rvalid=1 for exactly one cycle and m[rd_owner]_rdata := mem_dout.
  - Writes never assert rvalid.
- Back-to-back reads (including alternating owners) sustain one read per cycle.
- rdata holds its last value when rvalid=0.
- Reset mid-operation: a pending read return is discarded (no rvalid); arbitration restarts with m0 preferred.
- Simultaneous read return and new issue are independent; no stall.

Optional Feature:
- Macro: IO_ARB_HOST_PRIORITY_EN
- Defined:
  - Fixed priority: m0 always wins contention, except that m1 is granted when m0 has won 8 consecutive contended cycles (starvation guard, 3-bit counter, reset 0, cleared when m1 is granted).
  - m0_lock is then ignored and m1_lock is honoured as above.
- Undefined: round-robin with lock as specified in Behaviour.

Test Plan:
- Only m0 reads addr 0x010 (memory preloaded 0xDEADBEEF) -> m0_ready same cycle, mem_en=1, mem_addr=0x010; m0_rvalid=1, m0_rdata=0xDEADBEEF two edges after accept; m1_rvalid stays 0.
- Both valid continuously, no lock, m0 writes 0x11111111 to 0x004, m1 reads 0x008 -> grants alternate 0,1,0,1 starting with m0 after reset; m1_rvalid every second cycle.
- Both valid, m1 lock=1, MAX_BURST=4 -> m1 granted 4 consecutive cycles, then m0 granted once, then m1 again.
- m1 read accepted, reset asserted on the next cycle -> no m1_rvalid; after reset, contention grants m0 first.
- Alternating reads m0@0x020 / m1@0x021 every cycle -> each rvalid pulses with the correct owner's data and no dropped beats.
- With IO_ARB_HOST_PRIORITY_EN, both valid continuously -> m0 granted 8 cycles, m1 granted once, pattern repeats.

Source files
------------

// File: rtl/io_reg_arbiter.sv
// Two-requester arbiter for the GPU I/O-register BRAM port. Round-robin with short locked bursts by default;
// defining IO_ARB_HOST_PRIORITY_EN switches to fixed m0 priority with a starvation guard for m1.
`timescale 1ns/1ps
module io_reg_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                gpu_clk,
  input  logic                reset,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_we,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m0_lock,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             lock_q, lock_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;
  logic             rvalid_q [2];
  logic [DATA_W-1:0] rdata_q [2];

  logic             contended, hold_lock;
  logic             gnt_en, gnt_id, gnt_lock;
  logic [BE_W-1:0]  gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

`ifdef IO_ARB_HOST_PRIORITY_EN
  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       starve_q, starve_d;
`endif

  // lock_q remembers whether the most recent grant asked to keep the port
  always_comb begin
    contended = m0_valid & m1_valid;
    hold_lock = lock_q && (burst_cnt_q < CNT_MAX);
    gnt_en    = 1'b0;
    gnt_id    = 1'b0;
    if (!reset) begin
      if (contended) begin
        gnt_en = 1'b1;
`ifdef IO_ARB_HOST_PRIORITY_EN
        gnt_id = (last_gnt_q && hold_lock) || starve_q;
`else
        gnt_id = hold_lock ? last_gnt_q : ~last_gnt_q;
`endif
      end else if (m0_valid || m1_valid) begin
        gnt_en = 1'b1;
        gnt_id = m1_valid;
      end
    end
  end

  assign gnt_we    = gnt_id ? m1_we    : m0_we;
  assign gnt_addr  = gnt_id ? m1_addr  : m0_addr;
  assign gnt_wdata = gnt_id ? m1_wdata : m0_wdata;
  assign gnt_lock  = gnt_id ? m1_lock  : m0_lock;

  assign m0_ready = gnt_en & ~gnt_id;
  assign m1_ready = gnt_en & gnt_id;
  assign mem_en   = gnt_en;
  assign mem_we   = gnt_en ? gnt_we    : '0;
  assign mem_addr = gnt_en ? gnt_addr  : '0;
  assign mem_din  = gnt_en ? gnt_wdata : '0;

  always_comb begin
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    lock_d      = lock_q;
    rd_pend_d   = gnt_en && (gnt_we == '0);
    rd_owner_d  = gnt_id;
`ifdef IO_ARB_HOST_PRIORITY_EN
    starve_cnt_d = starve_cnt_q;
    starve_d     = starve_q;
`endif
    if (!gnt_en) begin
      burst_cnt_d = '0;
    end else begin
      if (gnt_id == last_gnt_q) begin
        burst_cnt_d = (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
      end else begin
        burst_cnt_d = '0;
        last_gnt_d  = gnt_id;
      end
`ifdef IO_ARB_HOST_PRIORITY_EN
      lock_d = gnt_id & m1_lock;
      if (gnt_id) begin
        starve_cnt_d = '0;
        starve_d     = 1'b0;
      end else if (contended) begin
        // eighth consecutive contended m0 win arms the guard for m1
        starve_cnt_d = starve_cnt_q + 1'b1;
        if (starve_cnt_q == 3'd7) starve_d = 1'b1;
      end
`else
      lock_d = gnt_lock;
`endif
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      lock_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
`ifdef IO_ARB_HOST_PRIORITY_EN
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
`endif
    end else begin
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      lock_q      <= lock_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
`ifdef IO_ARB_HOST_PRIORITY_EN
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
`endif
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    always_ff @(posedge gpu_clk) begin
      if (reset) begin
        rvalid_q[gi] <= 1'b0;
        rdata_q[gi]  <= '0;
      end else begin
        rvalid_q[gi] <= rd_pend_q && (rd_owner_q == 1'(gi));
        if (rd_pend_q && (rd_owner_q == 1'(gi))) rdata_q[gi] <= mem_dout;
      end
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_io_reg_arbiter.sv
// Self-checking bench for io_reg_arbiter: directed scenarios plus randomized traffic against a cycle-level
// reference model (grant rules, shadow memory, read-return scoreboard).
`timescale 1ns/1ps
module tb_io_reg_arbiter;
  localparam int AW = 12, DW = 32, BW = 4, MAXB = 4;

  logic gpu_clk = 1'b0;
  logic reset = 1'b1;
  logic m0_valid = 1'b0, m0_ready, m0_lock = 1'b0, m0_rvalid;
  logic [AW-1:0] m0_addr = '0;
  logic [BW-1:0] m0_we = '0;
  logic [DW-1:0] m0_wdata = '0, m0_rdata;
  logic m1_valid = 1'b0, m1_ready, m1_lock = 1'b0, m1_rvalid;
  logic [AW-1:0] m1_addr = '0;
  logic [BW-1:0] m1_we = '0;
  logic [DW-1:0] m1_wdata = '0, m1_rdata;
  logic mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  always #5 gpu_clk = ~gpu_clk;

  io_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .gpu_clk(gpu_clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // BRAM stand-in: registered read-first port with byte writes
  logic [DW-1:0] tb_mem [0:4095];
  always @(posedge gpu_clk) begin
    if (mem_en) begin
      mem_dout <= tb_mem[mem_addr];
      for (int b = 0; b < BW; b++) if (mem_we[b]) tb_mem[mem_addr][8*b +: 8] = mem_din[8*b +: 8];
    end
  end

  // reference model state
  logic [DW-1:0] shadow [0:4095];
  typedef struct { int due; int owner; logic [DW-1:0] data; } ret_t;
  ret_t ret_q[$];
  int m_last, m_run, m_starve, m_gnt, cyc;
  bit m_lock;
  logic [1:0] exp_rv;
  logic [DW-1:0] exp_rdata [2];
  int tests_run = 0, tests_failed = 0;

  function automatic int model_pick();
    if (reset || (!m0_valid && !m1_valid)) return -1;
    if (!(m0_valid && m1_valid)) return m1_valid ? 1 : 0;
`ifdef IO_ARB_HOST_PRIORITY_EN
    if (m_last == 1 && m_lock && m_run < MAXB) return 1;
    if (m_starve >= 8) return 1;
    return 0;
`else
    if (m_lock && m_run < MAXB) return m_last;
    return 1 - m_last;
`endif
  endfunction

  task automatic model_reset();
    m_last = 1; m_run = 1; m_lock = 0; m_starve = 0;
    ret_q.delete(); exp_rv = '0; exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  // advance one clock, updating the model with the grant it predicts for the current inputs
  task automatic tick();
    int g; bit cont, lk; ret_t r;
    logic [AW-1:0] a; logic [BW-1:0] we; logic [DW-1:0] wd;
    g = model_pick(); cont = m0_valid && m1_valid;
    a = (g == 1) ? m1_addr : m0_addr;
    we = (g == 1) ? m1_we : m0_we;
    wd = (g == 1) ? m1_wdata : m0_wdata;
    lk = (g == 1) ? m1_lock : m0_lock;
    @(posedge gpu_clk);
    cyc++;
    m_gnt = g;
    if (reset) model_reset();
    else begin
      exp_rv = '0;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        r = ret_q.pop_front();
        exp_rv[r.owner] = 1'b1;
        exp_rdata[r.owner] = r.data;
      end
      if (g < 0) m_run = 1;
      else begin
        if (g == m_last) m_run++;
        else begin m_last = g; m_run = 1; end
`ifdef IO_ARB_HOST_PRIORITY_EN
        m_lock = (g == 1) && lk;
        if (g == 1) m_starve = 0; else if (cont) m_starve++;
`else
        m_lock = lk;
`endif
        if (we == '0) begin
          r.due = cyc + 1; r.owner = g; r.data = shadow[a];
          ret_q.push_back(r);
        end else begin
          for (int b = 0; b < BW; b++) if (we[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic new_req(input int who);
    logic [AW-1:0] a; logic [BW-1:0] we; logic [DW-1:0] wd; bit lk;
    a = AW'($urandom_range(0, 15));
    we = ($urandom_range(0, 1) == 1) ? '0 : BW'($urandom_range(1, 15));
    wd = $urandom;
    lk = ($urandom_range(0, 3) == 0);
    if (who == 0) begin m0_valid = 1; m0_addr = a; m0_we = we; m0_wdata = wd; m0_lock = lk; end
    else begin m1_valid = 1; m1_addr = a; m1_we = we; m1_wdata = wd; m1_lock = lk; end
  endtask

  task automatic test_reset();
    reset = 1'b1; m0_valid = 0; m1_valid = 0;
    tick(); tick();
    tests_run++;
    if ({m1_ready, m0_ready, mem_en} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_handshake: got %b expected 000", {m1_ready, m0_ready, mem_en});
    end
    tests_run++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00 || m0_rdata !== '0 || m1_rdata !== '0) begin
      tests_failed++; $display("FAIL reset_rdata: got rv=%b %h %h expected 00 0 0", {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    m0_valid = 1; m0_addr = 12'h010; m0_we = '0; m0_lock = 0;
    #1;
    tests_run++;
    if ({m1_ready, m0_ready, mem_en} !== 3'b011 || mem_addr !== 12'h010 || mem_we !== '0) begin
      tests_failed++; $display("FAIL single_issue: got rdy/en=%b addr=%h we=%h expected 011 010 0", {m1_ready, m0_ready, mem_en}, mem_addr, mem_we);
    end
    tick(); m0_valid = 0; #1;
    tests_run++;
    if (m0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_early: got rvalid=%b expected 0", m0_rvalid); end
    tick();
    tests_run++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
      tests_failed++; $display("FAIL single_return: got rv0=%b d=%h rv1=%b expected 1 deadbeef 0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    tick();
    tests_run++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL single_hold: got rv0=%b d=%h expected 0 deadbeef", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    bit exp_m1, exp_rv1;
    do_reset();
    m0_valid = 1; m0_addr = 12'h004; m0_we = 4'hF; m0_wdata = 32'h11111111; m0_lock = 0;
    m1_valid = 1; m1_addr = 12'h008; m1_we = '0; m1_lock = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_m1 = (i % 2 == 1);
      exp_rv1 = (i >= 3) && (i % 2 == 1);
      tests_run++;
      if ({m1_ready, m0_ready} !== {exp_m1, !exp_m1} ||
          (!exp_m1 && (mem_addr !== 12'h004 || mem_we !== 4'hF || mem_din !== 32'h11111111))) begin
        tests_failed++; $display("FAIL rr_grant[%0d]: got rdy=%b addr=%h din=%h expected rdy=%b", i, {m1_ready, m0_ready}, mem_addr, mem_din, {exp_m1, !exp_m1});
      end
      tests_run++;
      if (m1_rvalid !== exp_rv1 || (exp_rv1 && m1_rdata !== 32'hC0DE0008) || m0_rvalid !== 1'b0) begin
        tests_failed++; $display("FAIL rr_return[%0d]: got rv1=%b d=%h rv0=%b expected rv1=%b d=c0de0008", i, m1_rvalid, m1_rdata, m0_rvalid, exp_rv1);
      end
      tick();
    end
    m0_valid = 0; m1_valid = 0;
    tick(); tick();
  endtask

  task automatic test_lock_burst();
    logic [9:0] pat;
    pat = 10'b1111011110;
    do_reset();
    m0_valid = 1; m0_addr = 12'h001; m0_we = '0; m0_lock = 0;
    m1_valid = 1; m1_addr = 12'h002; m1_we = '0; m1_lock = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (m1_ready !== pat[i] || m0_ready !== !pat[i]) begin
        tests_failed++; $display("FAIL lock_grant[%0d]: got rdy=%b expected m1=%b", i, {m1_ready, m0_ready}, pat[i]);
      end
      tick();
    end
    m0_valid = 0; m1_valid = 0; m1_lock = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m1_valid = 1; m1_addr = 12'h003; m1_we = '0;
    #1;
    tests_run++;
    if ({m1_ready, m0_ready} !== 2'b10) begin tests_failed++; $display("FAIL rst_mid_first: got rdy=%b expected 10", {m1_ready, m0_ready}); end
    tick(); m1_valid = 0; tick(); tick();
    tests_run++;
    if (m1_rdata !== 32'hC0DE0003) begin tests_failed++; $display("FAIL rst_mid_pre: got %h expected c0de0003", m1_rdata); end
    m1_valid = 1; m1_addr = 12'h005;
    tick(); m1_valid = 0; reset = 1;
    tick(); reset = 0; #1;
    tests_run++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== '0) begin
      tests_failed++; $display("FAIL rst_mid_drop: got rv1=%b d=%h expected 0 0", m1_rvalid, m1_rdata);
    end
    tick();
    tests_run++;
    if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_late: got rv1=%b expected 0", m1_rvalid); end
    m0_valid = 1; m0_addr = 12'h006; m0_we = '0; m1_valid = 1; m1_addr = 12'h007; m1_we = '0;
    #1;
    tests_run++;
    if ({m1_ready, m0_ready} !== 2'b01) begin tests_failed++; $display("FAIL rst_mid_contend: got rdy=%b expected 01", {m1_ready, m0_ready}); end
    tick(); m0_valid = 0; m1_valid = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_alternating_reads();
    int pulses;
    pulses = 0;
    do_reset();
    m0_valid = 1; m0_addr = 12'h020; m0_we = '0; m0_lock = 0;
    m1_valid = 1; m1_addr = 12'h021; m1_we = '0; m1_lock = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 12) begin m0_valid = 0; m1_valid = 0; end
      #1;
      pulses += int'(m0_rvalid) + int'(m1_rvalid);
      tests_run++;
      if ({m1_rvalid, m0_rvalid} !== exp_rv || m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1]) begin
        tests_failed++; $display("FAIL alt_return[%0d]: got rv=%b %h %h expected rv=%b %h %h", i, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, exp_rv, exp_rdata[0], exp_rdata[1]);
      end
      tick();
    end
    tests_run++;
    if (pulses !== 12) begin tests_failed++; $display("FAIL alt_beats: got %0d expected 12", pulses); end
  endtask

`ifdef IO_ARB_HOST_PRIORITY_EN
  task automatic test_host_priority();
    bit exp_m1;
    do_reset();
    m0_valid = 1; m0_addr = 12'h030; m0_we = '0; m0_lock = 1;
    m1_valid = 1; m1_addr = 12'h031; m1_we = '0; m1_lock = 0;
    for (int i = 0; i < 18; i++) begin
      #1;
      exp_m1 = (i == 8) || (i == 17);
      tests_run++;
      if ({m1_ready, m0_ready} !== {exp_m1, !exp_m1}) begin
        tests_failed++; $display("FAIL prio_grant[%0d]: got rdy=%b expected m1=%b", i, {m1_ready, m0_ready}, exp_m1);
      end
      tick();
    end
    m0_valid = 0; m1_valid = 0; m0_lock = 0;
    tick(); tick();
  endtask
`endif

  task automatic test_random();
    int g;
    logic [AW-1:0] ea; logic [BW-1:0] ew; logic [DW-1:0] ed;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1; m0_valid = 0; m1_valid = 0;
      end else begin
        reset = 0;
        if (!m0_valid && $urandom_range(0, 9) < 6) new_req(0);
        if (!m1_valid && $urandom_range(0, 9) < 6) new_req(1);
      end
      #1;
      g = model_pick();
      ea = (g == 0) ? m0_addr : (g == 1) ? m1_addr : '0;
      ew = (g == 0) ? m0_we : (g == 1) ? m1_we : '0;
      ed = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0;
      tests_run++;
      if ({m1_ready, m0_ready, mem_en} !== {g == 1, g == 0, g >= 0}) begin
        tests_failed++; $display("FAIL rnd_grant[%0d]: got rdy/en=%b expected grant %0d", i, {m1_ready, m0_ready, mem_en}, g);
      end
      tests_run++;
      if (mem_addr !== ea || mem_we !== ew || mem_din !== ed) begin
        tests_failed++; $display("FAIL rnd_mem[%0d]: got %h/%h/%h expected %h/%h/%h", i, mem_addr, mem_we, mem_din, ea, ew, ed);
      end
      tests_run++;
      if ({m1_rvalid, m0_rvalid} !== exp_rv || m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1]) begin
        tests_failed++; $display("FAIL rnd_return[%0d]: got rv=%b %h %h expected rv=%b %h %h", i, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, exp_rv, exp_rdata[0], exp_rdata[1]);
      end
      tick();
      if (m_gnt == 0) m0_valid = 0;
      if (m_gnt == 1) m1_valid = 0;
    end
    reset = 0; m0_valid = 0; m1_valid = 0;
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tb_mem[i] = 32'hC0DE0000 | i;
      shadow[i] = 32'hC0DE0000 | i;
    end
    tb_mem[12'h010] = 32'hDEADBEEF;
    shadow[12'h010] = 32'hDEADBEEF;
    cyc = 0; m_gnt = -1;
    model_reset();
    test_reset();
    test_single_read();
`ifndef IO_ARB_HOST_PRIORITY_EN
    test_round_robin();
    test_lock_burst();
`else
    test_host_priority();
`endif
    test_reset_mid_read();
    test_alternating_reads();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
